// File: rtl/lane_seq_pkg.sv
// lane_seq_pkg
//   Shared definitions for the lane event sequencer: FIFO entry layout,
//   op and mode encodings, and the driver state enum.
//   Entry layout: {op[1:0], plate[4:0]}; departures carry plate 0.
package lane_seq_pkg;

  localparam int ENTRY_W = 7;

  localparam logic [1:0] OP_REMA = 2'd0;
  localparam logic [1:0] OP_REMB = 2'd1;
  localparam logic [1:0] OP_ADDA = 2'd2;
  localparam logic [1:0] OP_ADDB = 2'd3;

  localparam logic [2:0] MODE_IDLE    = 3'b000;
  localparam logic [2:0] MODE_DISPLAY = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
  } drv_state_e;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [1:0] op,
                                                    input logic [4:0] plate);
    return {op, plate};
  endfunction

endpackage

// File: rtl/lane_seq_fifo.sv
// lane_seq_fifo
//   Synchronous FIFO with full/empty flags. A push while full is accepted
//   only when a pop happens in the same cycle (the pop frees the slot).
//   Pops while empty are ignored.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   push, wdata    write request and data
//   pop            read request; rdata shows the head combinationally
//   full, empty    occupancy flags
module lane_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lane_event_sequencer.sv
// lane_event_sequencer
//   Arbitrates lane A/B arrival and departure requests into one event
//   stream (priority depA > depB > arrA > arrB), buffers it in a FIFO and
//   replays each event downstream as mode/plate setup, one action pulse,
//   and a hold phase. Projected lane counts (committed + queued) gate
//   acceptance so no removal hits an empty lane and no add a full lane.
//   Optional build macro DROP_COUNTER_EN adds drop_count, a saturating
//   count of cycles where a request was refused only by its lane check.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   arrA/arrB_valid/plate/ready      arrival handshakes
//   depA/depB_valid/ready            departure handshakes
//   disp_req                         display-mode level request (IDLE only)
//   mode, plateOut, action           downstream event interface
//   carsA, carsB                     committed lane occupancy
//   busy                             FIFO non-empty or driver active
//   drop_count                       (DROP_COUNTER_EN only)
//
//   state    | meaning
//   ST_IDLE  | no event in flight; pop head or show idle/display mode
//   ST_SETUP | mode/plate stable, action low, SETUP_CYC cycles
//   ST_PULSE | action high, PULSE_CYC cycles; lane count committed on entry
//   ST_HOLD  | action low, mode/plate held, HOLD_CYC cycles
module lane_event_sequencer
  import lane_seq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MAX_CARS  = 30,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arrA_valid,
  input  logic [4:0] arrA_plate,
  output logic       arrA_ready,
  input  logic       arrB_valid,
  input  logic [4:0] arrB_plate,
  output logic       arrB_ready,
  input  logic       depA_valid,
  output logic       depA_ready,
  input  logic       depB_valid,
  output logic       depB_ready,
  input  logic       disp_req,
  output logic [2:0] mode,
  output logic [4:0] plateOut,
  output logic       action,
  output logic [4:0] carsA,
  output logic [4:0] carsB,
  output logic       busy
`ifdef DROP_COUNTER_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int CNT_MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CNT_MAX    = (CNT_MAX_SP > HOLD_CYC) ? CNT_MAX_SP : HOLD_CYC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [4:0] MAX_C = 5'(MAX_CARS);

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;

  logic [4:0]  projA_q, projB_q;
  logic        space;
  logic        remA_ok, remB_ok, addA_ok, addB_ok;
  logic        gnt_depA, gnt_depB, gnt_arrA, gnt_arrB;

  drv_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       mode_q;
  logic [4:0]       plate_q;
  logic             action_q;
  logic [4:0]       carsA_q, carsB_q;

  // Popping in IDLE frees a slot, so a full FIFO can still accept that cycle.
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
  assign space    = !fifo_full || fifo_pop;
  assign remA_ok  = (projA_q != '0);
  assign remB_ok  = (projB_q != '0);
  assign addA_ok  = (projA_q < MAX_C);
  assign addB_ok  = (projB_q < MAX_C);

  always_comb begin
    gnt_depA   = 1'b0;
    gnt_depB   = 1'b0;
    gnt_arrA   = 1'b0;
    gnt_arrB   = 1'b0;
    fifo_wdata = '0;
    if (rst_n && space) begin
      if (depA_valid && remA_ok)      gnt_depA = 1'b1;
      else if (depB_valid && remB_ok) gnt_depB = 1'b1;
      else if (arrA_valid && addA_ok) gnt_arrA = 1'b1;
      else if (arrB_valid && addB_ok) gnt_arrB = 1'b1;
    end
    if (gnt_depA)      fifo_wdata = pack_entry(OP_REMA, 5'd0);
    else if (gnt_depB) fifo_wdata = pack_entry(OP_REMB, 5'd0);
    else if (gnt_arrA) fifo_wdata = pack_entry(OP_ADDA, arrA_plate);
    else if (gnt_arrB) fifo_wdata = pack_entry(OP_ADDB, arrB_plate);
  end

  assign fifo_push  = gnt_depA | gnt_depB | gnt_arrA | gnt_arrB;
  assign depA_ready = gnt_depA;
  assign depB_ready = gnt_depB;
  assign arrA_ready = gnt_arrA;
  assign arrB_ready = gnt_arrB;

  lane_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Projected counts move at push time so back-to-back requests see queued work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      projA_q <= '0;
      projB_q <= '0;
    end else begin
      if (gnt_depA)      projA_q <= projA_q - 1'b1;
      else if (gnt_depB) projB_q <= projB_q - 1'b1;
      else if (gnt_arrA) projA_q <= projA_q + 1'b1;
      else if (gnt_arrB) projB_q <= projB_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= MODE_IDLE;
      plate_q  <= '0;
      action_q <= 1'b0;
      carsA_q  <= '0;
      carsB_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          action_q <= 1'b0;
          if (!fifo_empty) begin
            mode_q  <= {1'b0, fifo_rdata[ENTRY_W-1 -: 2]};
            plate_q <= fifo_rdata[4:0];
            cnt_q   <= CNT_W'(SETUP_CYC - 1);
            state_q <= ST_SETUP;
          end else begin
            mode_q  <= disp_req ? MODE_DISPLAY : MODE_IDLE;
            plate_q <= '0;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_q  <= ST_PULSE;
            action_q <= 1'b1;
            cnt_q    <= CNT_W'(PULSE_CYC - 1);
            // mode_q[1:0] is the op of the in-flight event.
            case (mode_q[1:0])
              OP_REMA: carsA_q <= carsA_q - 1'b1;
              OP_REMB: carsB_q <= carsB_q - 1'b1;
              OP_ADDA: carsA_q <= carsA_q + 1'b1;
              OP_ADDB: carsB_q <= carsB_q + 1'b1;
              default: ;
            endcase
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_q  <= ST_HOLD;
            action_q <= 1'b0;
            cnt_q    <= CNT_W'(HOLD_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) state_q <= ST_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mode     = mode_q;
  assign plateOut = plate_q;
  assign action   = action_q;
  assign carsA    = carsA_q;
  assign carsB    = carsB_q;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);

`ifdef DROP_COUNTER_EN
  logic       lane_refused;
  logic [7:0] drop_q;

  // With FIFO space available, a refused valid request failed only its lane check.
  assign lane_refused = space && ((depA_valid && !remA_ok) || (depB_valid && !remB_ok) ||
                                  (arrA_valid && !addA_ok) || (arrB_valid && !addB_ok));

  always_ff @(posedge clk) begin
    if (!rst_n)                             drop_q <= '0;
    else if (lane_refused && drop_q != '1)  drop_q <= drop_q + 1'b1;
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_lane_event_sequencer.sv
module tb_lane_event_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arrA_valid, arrB_valid, depA_valid, depB_valid, disp_req;
  logic [4:0] arrA_plate, arrB_plate;
  logic       arrA_ready, arrB_ready, depA_ready, depB_ready;
  logic [2:0] mode;
  logic [4:0] plateOut, carsA, carsB;
  logic       action, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { int cyc; int mode; int plate; } pulse_t;
  pulse_t plog[$];

  lane_event_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arrA_valid (arrA_valid),
    .arrA_plate (arrA_plate),
    .arrA_ready (arrA_ready),
    .arrB_valid (arrB_valid),
    .arrB_plate (arrB_plate),
    .arrB_ready (arrB_ready),
    .depA_valid (depA_valid),
    .depA_ready (depA_ready),
    .depB_valid (depB_valid),
    .depB_ready (depB_ready),
    .disp_req   (disp_req),
    .mode       (mode),
    .plateOut   (plateOut),
    .action     (action),
    .carsA      (carsA),
    .carsB      (carsB),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (action === 1'b1) plog.push_back('{cyc, int'(mode), int'(plateOut)});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
    nxt();
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] exp_rdy;
    int          exp_mode[3];
    int          exp_plate[3];
    int          next_plate, acc, n, refused;

    rst_n = 1'b0;
    arrA_valid = 1'b1; arrB_valid = 1'b0; depA_valid = 1'b0; depB_valid = 1'b0;
    disp_req = 1'b0; arrA_plate = 5'd4; arrB_plate = '0;

    // Reset values, with a request pending during reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mode", mode, 0);
    check("rst_plate", plateOut, 0);
    check("rst_action", action, 0);
    check("rst_arrA_ready", arrA_ready, 0);
    check("rst_carsA", carsA, 0);
    check("rst_carsB", carsB, 0);
    check("rst_busy", busy, 0);
    nxt();
    rst_n = 1'b1; arrA_valid = 1'b0;
    nxt();

    // Lane A add, plate 9
    arrA_valid = 1'b1; arrA_plate = 5'd9;
    @(negedge clk);
    check("t1_ready", arrA_ready, 1);
    check("t1_busy_c0", busy, 0);
    nxt();
    arrA_valid = 1'b0; arrA_plate = '0;
    @(negedge clk);
    check("t1_busy_c1", busy, 1);
    check("t1_mode_c1", mode, 0);
    nxt(); @(negedge clk);
    check("t1_mode_c2", mode, 3'b010);
    check("t1_plate_c2", plateOut, 9);
    check("t1_action_c2", action, 0);
    nxt(); @(negedge clk);
    check("t1_action_c3", action, 1);
    check("t1_carsA_c3", carsA, 1);
    nxt(); @(negedge clk);
    check("t1_action_c4", action, 0);
    check("t1_mode_c4", mode, 3'b010);
    wait_idle("t1", 20);
    check("t1_mode_after", mode, 0);

    // Removal on empty lane B is never accepted
    plog.delete();
    depB_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t2_depB_ready%0d", i), depB_ready, 0);
      nxt();
    end
    depB_valid = 1'b0;
    @(negedge clk);
    check("t2_no_event", plog.size(), 0);
    check("t2_busy", busy, 0);
    nxt();

    // Simultaneous depA, arrA, arrB with lane A holding one car
    plog.delete();
    depA_valid = 1'b1; arrA_valid = 1'b1; arrA_plate = 5'd3; arrB_valid = 1'b1; arrB_plate = 5'd17;
    @(negedge clk);
    check("t3_c0_depA", depA_ready, 1);
    check("t3_c0_arrA", arrA_ready, 0);
    check("t3_c0_arrB", arrB_ready, 0);
    nxt();
    depA_valid = 1'b0;
    @(negedge clk);
    check("t3_c1_arrA", arrA_ready, 1);
    check("t3_c1_arrB", arrB_ready, 0);
    nxt();
    arrA_valid = 1'b0;
    @(negedge clk);
    check("t3_c2_arrB", arrB_ready, 1);
    nxt();
    arrB_valid = 1'b0;
    wait_idle("t3", 40);
    exp_mode  = '{0, 2, 3};
    exp_plate = '{0, 3, 17};
    check("t3_npulses", plog.size(), 3);
    for (int i = 0; i < 3 && i < plog.size(); i++) begin
      check($sformatf("t3_mode%0d", i), plog[i].mode, exp_mode[i]);
      check($sformatf("t3_plate%0d", i), plog[i].plate, exp_plate[i]);
      if (i > 0) check($sformatf("t3_gap%0d", i), plog[i].cyc - plog[i-1].cyc, 4);
    end
    check("t3_carsA", carsA, 1);
    check("t3_carsB", carsB, 1);

    // FIFO full: continuous lane A adds; ready drops while 8 entries wait
    plog.delete();
    exp_rdy = 14'b10011111111111;
    next_plate = 1;
    for (int f = 0; f < 14; f++) begin
      arrA_valid = 1'b1; arrA_plate = 5'(next_plate);
      @(negedge clk);
      check($sformatf("t4_ready%0d", f), arrA_ready, exp_rdy[f]);
      if (arrA_ready) next_plate++;
      nxt();
    end
    arrA_valid = 1'b0;
    wait_idle("t4", 100);
    check("t4_npulses", plog.size(), 12);
    for (int i = 0; i < plog.size(); i++) begin
      check($sformatf("t4_plate%0d", i), plog[i].plate, i + 1);
      check($sformatf("t4_mode%0d", i), plog[i].mode, 2);
    end
    check("t4_carsA", carsA, 13);

    // Lane capacity: 30 adds accepted, 31st refused
    rst_n = 1'b0;
    nxt(); nxt();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_carsA_rst", carsA, 0);
    nxt();
    acc = 0; n = 0;
    while (acc < 30 && n < 600) begin
      arrA_valid = 1'b1; arrA_plate = 5'(acc);
      @(negedge clk);
      if (arrA_ready) acc++;
      n++;
      nxt();
    end
    check("t5_accepts", acc, 30);
    refused = 0; n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      if (arrA_ready) refused++;
      @(negedge clk);
      n++;
    end
    if (arrA_ready) refused++;
    check("t5_31st_refused", refused, 0);
    check("t5_drained", busy, 0);
    check("t5_carsA", carsA, 30);
    nxt();
    arrB_valid = 1'b1; arrB_plate = 5'd7;
    @(negedge clk);
    check("t5_arrA_full", arrA_ready, 0);
    check("t5_arrB_ok", arrB_ready, 1);
    nxt();
    arrA_valid = 1'b0; arrB_valid = 1'b0;
    wait_idle("t5", 20);
    check("t5_carsB", carsB, 1);

    // Display request raised during PULSE takes effect only after HOLD
    arrB_valid = 1'b1; arrB_plate = 5'd5;
    @(negedge clk);
    check("t6_ready", arrB_ready, 1);
    nxt();
    arrB_valid = 1'b0;
    nxt();
    nxt();
    disp_req = 1'b1;
    @(negedge clk);
    check("t6_pulse_action", action, 1);
    check("t6_pulse_mode", mode, 3'b011);
    nxt(); @(negedge clk);
    check("t6_hold_action", action, 0);
    check("t6_hold_mode", mode, 3'b011);
    check("t6_hold_plate", plateOut, 5);
    nxt(); nxt(); @(negedge clk);
    check("t6_display_mode", mode, 3'b100);
    check("t6_display_plate", plateOut, 0);
    nxt();
    disp_req = 1'b0;
    nxt(); @(negedge clk);
    check("t6_mode_back", mode, 0);
    check("t6_carsB", carsB, 2);
    nxt();

    // Reset mid-PULSE discards the in-flight and queued events
    for (int i = 0; i < 3; i++) begin
      arrB_valid = 1'b1; arrB_plate = 5'(6 + i);
      @(negedge clk);
      check($sformatf("t7_ready%0d", i), arrB_ready, 1);
      nxt();
    end
    arrB_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_pulse_before_rst", action, 1);
    nxt(); @(negedge clk);
    check("t7_rst_action", action, 0);
    check("t7_rst_mode", mode, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_carsB", carsB, 0);
    check("t7_rst_carsA", carsA, 0);
    nxt();
    rst_n = 1'b1;
    plog.delete();
    repeat (12) nxt();
    @(negedge clk);
    check("t7_no_replay", plog.size(), 0);
    check("t7_busy_after", busy, 0);
    nxt();
    depA_valid = 1'b1; arrA_valid = 1'b1; arrA_plate = 5'd2;
    @(negedge clk);
    check("t7_depA_empty", depA_ready, 0);
    check("t7_arrA_wins", arrA_ready, 1);
    nxt();
    depA_valid = 1'b0; arrA_valid = 1'b0;
    wait_idle("t7", 20);
    check("t7_carsA", carsA, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
